uart_rx_data_sampling: RTL

UART_RX_DATA_SAMPLING -- requirements
Module: UART_RX_data_sampling

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_sync2.sv | 24 ++
 rtl/uart_rx_data_sampling.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX data-sampling block.
// Holds the sampler FSM state type, the legal oversampling ratios,
// the edge-count width and small vote helpers used by the sampler.
package uart_rx_pkg;

  localparam int EDGE_CNT_W = 5;
  localparam int PRESCALE_W = 6;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MID = 2'd1,
    SAMPLE   = 2'd2,
    VALID    = 2'd3
  } state_t;

  // Only these oversampling ratios place three sample points cleanly mid-bit.
  function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic disagree3(input logic a, input logic b, input logic c);
    return !((a == b) && (b == c));
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so the line reads idle-high while the block is in reset.
module uart_rx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make meta and q shift together; blocking would collapse the chain into one flop.
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_data_sampling.sv
// UART RX data sampler: takes three samples of the synchronized line around
// the middle of each bit period, majority-votes them and flags the result
// as valid for the rest of the bit.
// Optional build macro UART_RX_NOISE_DET_EN adds the noise_err detector;
// without it noise_err is tied low.
module uart_rx_data_sampling
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [EDGE_CNT_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sample_out_flag,
  output logic                  noise_err
);

  logic                  rx_sync;
  state_t                state;
  logic                  sample0;
  logic                  sample1;
  logic                  got_mid;

  logic [PRESCALE_W-1:0] edge_ext;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_m1;
  logic [PRESCALE_W-1:0] mid_p1;
  logic [PRESCALE_W-1:0] mid_p2;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  run;
  logic                  vote;
  logic                  valid_hold;

  uart_rx_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (RX_IN),
    .q     (rx_sync)
  );

  // Sample-point positions and the qualified vote/hold conditions.
  always_comb begin
    edge_ext   = {1'b0, edge_cnt};
    mid        = prescale >> 1;
    mid_m1     = mid - 6'd1;
    mid_p1     = mid + 6'd1;
    mid_p2     = mid + 6'd2;
    last_edge  = prescale - 6'd1;
    run        = dat_samp_en && prescale_legal(prescale);
    vote       = run && (state == SAMPLE) && got_mid && (edge_ext == mid_p1);
    // Leaving VALID at the last edge of the bit, or if the count wrapped early.
    valid_hold = run && (state == VALID) &&
                 (edge_ext != last_edge) && (edge_ext >= mid_p2);
  end

  // Sampler FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state           <= IDLE;
      sample0         <= 1'b1;
      sample1         <= 1'b1;
      got_mid         <= 1'b0;
      sampled_bit     <= 1'b1;
      sample_out_flag <= 1'b0;
    end else if (!run) begin
      // Disabled or unusable ratio: drop any partial bit, keep the last vote.
      state           <= IDLE;
      sample0         <= 1'b1;
      sample1         <= 1'b1;
      got_mid         <= 1'b0;
      sample_out_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state           <= WAIT_MID;
          sample_out_flag <= 1'b0;
        end
        WAIT_MID: begin
          sample_out_flag <= 1'b0;
          if (edge_ext == mid_m1) begin
            sample0 <= rx_sync;
            got_mid <= 1'b0;
            state   <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (vote) begin
            sampled_bit     <= majority3(sample0, sample1, rx_sync);
            sample_out_flag <= 1'b1;
            got_mid         <= 1'b0;
            state           <= VALID;
          end else if ((edge_ext == mid) && !got_mid) begin
            sample1 <= rx_sync;
            got_mid <= 1'b1;
          end else begin
            // Count skipped a sample point: abandon this bit quietly.
            got_mid         <= 1'b0;
            sample_out_flag <= 1'b0;
            state           <= WAIT_MID;
          end
        end
        VALID: begin
          if (valid_hold) begin
            sample_out_flag <= 1'b1;
          end else begin
            sample_out_flag <= 1'b0;
            state           <= WAIT_MID;
          end
        end
        default: begin
          sample_out_flag <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_RX_NOISE_DET_EN
  // Noise flag: set at the vote when samples disagree, held through VALID.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      noise_err <= 1'b0;
    end else if (vote) begin
      noise_err <= disagree3(sample0, sample1, rx_sync);
    end else if (!valid_hold) begin
      noise_err <= 1'b0;
    end
  end
`else
  assign noise_err = 1'b0;
`endif

endmodule
